// File: rtl/jtdsp16_dau_ctrl_pkg.sv
// Shared opcode constants, sequencer states and the decoded strobe vector
// for the DSP16 DAU control path.
package jtdsp16_dau_ctrl_pkg;

  localparam logic [4:0] OP_F1   = 5'h06;
  localparam logic [4:0] OP_F1LD = 5'h04;
  localparam logic [4:0] OP_LDI  = 5'h0A;
  localparam logic [4:0] OP_RLD  = 5'h0C;
  localparam logic [4:0] OP_IFC  = 5'h13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IMM   = 2'd1,
    CWAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic       dec_en;
    logic       con_en;
    logic       ram_load;
    logic       rmux_load;
    logic       st_a0h;
    logic       st_a1h;
    logic       go_imm;
    logic       go_cwait;
    logic       is_f1;
    logic       set_r;
    logic [2:0] r_field;
    logic       set_op;
    logic [5:0] op_fields;
  } dec_t;

endpackage

// File: rtl/jtdsp16_dau_ctrl_dec.sv
// Combinational word decoder: maps one instruction word to the strobe vector
// and field updates it requests. Shared by the IDLE and CWAIT paths.
module jtdsp16_dau_ctrl_dec
  import jtdsp16_dau_ctrl_pkg::*;
(
  input  logic [15:0] ins,
  output dec_t        dec
);

  always_comb begin
    dec = '0;
    case (ins[15:11])
      OP_F1: begin
        dec.dec_en    = 1'b1;
        dec.is_f1     = 1'b1;
        dec.set_op    = 1'b1;
        dec.op_fields = ins[5:0];
      end
      OP_F1LD: begin
        dec.dec_en    = 1'b1;
        dec.ram_load  = 1'b1;
        dec.is_f1     = 1'b1;
        dec.set_op    = 1'b1;
        dec.op_fields = ins[5:0];
        dec.set_r     = 1'b1;
        dec.r_field   = ins[9:7];
      end
      OP_LDI: begin
        dec.go_imm  = 1'b1;
        dec.set_r   = 1'b1;
        dec.r_field = ins[6:4];
      end
      OP_RLD: begin
        dec.rmux_load = 1'b1;
        dec.st_a1h    = ins[10];
        dec.st_a0h    = ~ins[10];
      end
      OP_IFC: begin
        dec.con_en    = 1'b1;
        dec.go_cwait  = 1'b1;
        dec.set_op    = 1'b1;
        dec.op_fields = {1'b0, ins[4:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/jtdsp16_dau_ctrl.sv
// DAU control sequencer: accepts instruction words and emits registered,
// one-cycle control strobes, handling LDI, IF CON and accumulator-high loads.
module jtdsp16_dau_ctrl
  import jtdsp16_dau_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic [15:0] ins,
  input  logic        ins_valid,
  output logic        ins_ready,
  input  logic        con_result,
  output logic        dec_en,
  output logic        con_en,
  output logic        ram_load,
  output logic        imm_load,
  output logic        rmux_load,
  output logic        st_a0h,
  output logic        st_a1h,
  output logic [2:0]  r_field,
  output logic [5:0]  op_fields,
  output logic [15:0] long_imm,
  output logic        illegal
);

  state_t state;
  dec_t   dec;
  logic   accept;

  jtdsp16_dau_ctrl_dec u_dec (
    .ins (ins),
    .dec (dec)
  );

  // Every state can take a word every cycle; no bubbles between sequence words.
  assign ins_ready = (state == IDLE) || (state == IMM) || (state == CWAIT);
  assign accept    = ins_valid && ins_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dec_en    <= 1'b0;
      con_en    <= 1'b0;
      ram_load  <= 1'b0;
      imm_load  <= 1'b0;
      rmux_load <= 1'b0;
      st_a0h    <= 1'b0;
      st_a1h    <= 1'b0;
      illegal   <= 1'b0;
      r_field   <= '0;
      op_fields <= '0;
      long_imm  <= '0;
    end else if (cen) begin
      dec_en    <= 1'b0;
      con_en    <= 1'b0;
      ram_load  <= 1'b0;
      imm_load  <= 1'b0;
      rmux_load <= 1'b0;
      st_a0h    <= 1'b0;
      st_a1h    <= 1'b0;
      illegal   <= 1'b0;
      if (accept) begin
        case (state)
          IDLE: begin
            dec_en    <= dec.dec_en;
            con_en    <= dec.con_en;
            ram_load  <= dec.ram_load;
            rmux_load <= dec.rmux_load;
            st_a0h    <= dec.st_a0h;
            st_a1h    <= dec.st_a1h;
            if (dec.set_r)  r_field   <= dec.r_field;
            if (dec.set_op) op_fields <= dec.op_fields;
            if (dec.go_imm)        state <= IMM;
            else if (dec.go_cwait) state <= CWAIT;
            else                   state <= IDLE;
          end
          IMM: begin
            long_imm <= ins;
            imm_load <= 1'b1;
            state    <= IDLE;
          end
          CWAIT: begin
            // op_fields keep the condition code unless the word executes
            if (dec.is_f1) begin
              if (con_result) begin
                dec_en   <= dec.dec_en;
                ram_load <= dec.ram_load;
                if (dec.set_r) r_field <= dec.r_field;
                op_fields <= dec.op_fields;
              end
            end else begin
              illegal <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtdsp16_dau_ctrl.sv
// Self-checking bench for jtdsp16_dau_ctrl: directed scenarios plus a
// randomized stream checked against a behavioural sequence model.
module tb_jtdsp16_dau_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b1;
  logic [15:0] ins = '0;
  logic        ins_valid = 1'b0;
  logic        con_result = 1'b0;
  logic        ins_ready, dec_en, con_en, ram_load, imm_load, rmux_load;
  logic        st_a0h, st_a1h, illegal;
  logic [2:0]  r_field;
  logic [5:0]  op_fields;
  logic [15:0] long_imm;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model: what the DAU should see after each edge
  int          m_pending;   // 0 none, 1 waiting immediate, 2 waiting conditioned word
  logic        e_dec, e_con, e_ram, e_imm, e_rmux, e_a0, e_a1, e_ill;
  logic [2:0]  e_r;
  logic [5:0]  e_op;
  logic [15:0] e_li;

  jtdsp16_dau_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .con_result (con_result),
    .dec_en     (dec_en),
    .con_en     (con_en),
    .ram_load   (ram_load),
    .imm_load   (imm_load),
    .rmux_load  (rmux_load),
    .st_a0h     (st_a0h),
    .st_a1h     (st_a1h),
    .r_field    (r_field),
    .op_fields  (op_fields),
    .long_imm   (long_imm),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    int op;
    if (rst) begin
      m_pending = 0;
      {e_dec, e_con, e_ram, e_imm, e_rmux, e_a0, e_a1, e_ill} = '0;
      e_r = '0; e_op = '0; e_li = '0;
    end else if (cen) begin
      {e_dec, e_con, e_ram, e_imm, e_rmux, e_a0, e_a1, e_ill} = '0;
      if (ins_valid) begin
        op = int'(ins[15:11]);
        if (m_pending == 1) begin
          e_li = ins; e_imm = 1'b1; m_pending = 0;
        end else if (m_pending == 2) begin
          if (op == 6 || op == 4) begin
            if (con_result) begin
              e_dec = 1'b1;
              e_op  = ins[5:0];
              if (op == 4) begin e_ram = 1'b1; e_r = ins[9:7]; end
            end
          end else e_ill = 1'b1;
          m_pending = 0;
        end else begin
          case (op)
            6:  begin e_dec = 1'b1; e_op = ins[5:0]; end
            4:  begin e_dec = 1'b1; e_ram = 1'b1; e_op = ins[5:0]; e_r = ins[9:7]; end
            10: begin e_r = ins[6:4]; m_pending = 1; end
            12: begin e_rmux = 1'b1; e_a1 = ins[10]; e_a0 = !ins[10]; end
            19: begin e_con = 1'b1; e_op = {1'b0, ins[4:0]}; m_pending = 2; end
            default: ;
          endcase
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cen = 1'b1; ins_valid = 1'b0;
    cyc(); cyc();
    n_checks++;
    if ({dec_en, con_en, ram_load, imm_load, rmux_load, st_a0h, st_a1h, illegal} !== 8'h00) begin
      n_fail++; $display("FAIL reset_strobes got=%b want=0", {dec_en, con_en, ram_load, imm_load, rmux_load, st_a0h, st_a1h, illegal});
    end
    n_checks++;
    if ({r_field, op_fields, long_imm} !== 25'd0) begin
      n_fail++; $display("FAIL reset_fields got r=%0d op=%h li=%h want 0", r_field, op_fields, long_imm);
    end
    n_checks++;
    if (ins_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", ins_ready); end
    rst = 1'b0;
  endtask

  task automatic test_f1();
    ins = 16'h3005; ins_valid = 1'b1;
    cyc();
    ins_valid = 1'b0;
    n_checks++;
    if (dec_en !== 1'b1 || op_fields !== 6'h05) begin
      n_fail++; $display("FAIL f1_exec got dec_en=%b op=%h want 1 05", dec_en, op_fields);
    end
    n_checks++;
    if ({con_en, ram_load, imm_load, rmux_load, st_a0h, st_a1h, illegal} !== 7'd0) begin
      n_fail++; $display("FAIL f1_others got=%b want=0", {con_en, ram_load, imm_load, rmux_load, st_a0h, st_a1h, illegal});
    end
    cyc();
    n_checks++;
    if (dec_en !== 1'b0) begin n_fail++; $display("FAIL f1_pulse got dec_en=%b want=0", dec_en); end
  endtask

  task automatic test_ldi();
    ins = 16'h5050; ins_valid = 1'b1;
    cyc();
    n_checks++;
    if ({dec_en, imm_load, con_en, rmux_load} !== 4'd0) begin
      n_fail++; $display("FAIL ldi_first got=%b want=0", {dec_en, imm_load, con_en, rmux_load});
    end
    ins = 16'h00A5;
    cyc();
    ins_valid = 1'b0;
    n_checks++;
    if (imm_load !== 1'b1 || r_field !== 3'd5 || long_imm !== 16'h00A5 || dec_en !== 1'b0) begin
      n_fail++; $display("FAIL ldi_second got imm=%b r=%0d li=%h dec=%b want 1 5 00a5 0", imm_load, r_field, long_imm, dec_en);
    end
    cyc();
  endtask

  task automatic test_rld();
    ins = 16'h6400; ins_valid = 1'b1;
    cyc();
    ins = 16'h6000;
    n_checks++;
    if ({rmux_load, st_a1h, st_a0h} !== 3'b110) begin
      n_fail++; $display("FAIL rld_a1 got=%b want=110", {rmux_load, st_a1h, st_a0h});
    end
    cyc();
    ins_valid = 1'b0;
    n_checks++;
    if ({rmux_load, st_a1h, st_a0h} !== 3'b101) begin
      n_fail++; $display("FAIL rld_a0 got=%b want=101", {rmux_load, st_a1h, st_a0h});
    end
    cyc();
  endtask

  task automatic test_ifc();
    for (int k = 0; k < 2; k++) begin
      ins = (k == 0) ? 16'h980E : 16'h980F; ins_valid = 1'b1;
      cyc();
      n_checks++;
      if (con_en !== 1'b1 || op_fields !== ((k == 0) ? 6'h0E : 6'h0F)) begin
        n_fail++; $display("FAIL ifc_con%0d got con_en=%b op=%h", k, con_en, op_fields);
      end
      ins = 16'h3003; con_result = (k == 0);
      cyc();
      ins_valid = 1'b0;
      n_checks++;
      if (con_en !== 1'b0 || dec_en !== (k == 0)) begin
        n_fail++; $display("FAIL ifc_exec%0d got con_en=%b dec_en=%b want 0 %0d", k, con_en, dec_en, k == 0);
      end
    end
    cyc();
  endtask

  task automatic test_ifc_wait();
    ins = 16'h9809; ins_valid = 1'b1; con_result = 1'b0;
    cyc();
    ins_valid = 1'b0;
    n_checks++;
    if (con_en !== 1'b1) begin n_fail++; $display("FAIL wait_con_first got=%b want=1", con_en); end
    for (int i = 0; i < 5; i++) begin
      con_result = i[0];
      cyc();
      n_checks++;
      if (con_en !== 1'b0 || op_fields !== 6'h09 || ins_ready !== 1'b1) begin
        n_fail++; $display("FAIL wait_hold%0d got con_en=%b op=%h rdy=%b want 0 09 1", i, con_en, op_fields, ins_ready);
      end
    end
    ins = 16'h3011; ins_valid = 1'b1; con_result = 1'b1;
    cyc();
    ins_valid = 1'b0;
    n_checks++;
    if (dec_en !== 1'b1 || op_fields !== 6'h11) begin
      n_fail++; $display("FAIL wait_exec got dec_en=%b op=%h want 1 11", dec_en, op_fields);
    end
    cyc();
  endtask

  task automatic test_illegal();
    ins = 16'h9801; ins_valid = 1'b1;
    cyc();
    ins = 16'h5030;
    cyc();
    n_checks++;
    if (illegal !== 1'b1 || imm_load !== 1'b0) begin
      n_fail++; $display("FAIL illegal_pulse got ill=%b imm=%b want 1 0", illegal, imm_load);
    end
    ins = 16'h3002;
    cyc();
    ins_valid = 1'b0;
    n_checks++;
    if (illegal !== 1'b0 || imm_load !== 1'b0 || dec_en !== 1'b1 || op_fields !== 6'h02) begin
      n_fail++; $display("FAIL illegal_after got ill=%b imm=%b dec=%b op=%h want 0 0 1 02", illegal, imm_load, dec_en, op_fields);
    end
    cyc();
  endtask

  task automatic test_cen_toggle();
    int pulses = 0;
    for (int i = 0; i < 4; i++) begin
      ins = 16'h3000 | 16'(i + 8); ins_valid = 1'b1; cen = 1'b1;
      cyc();
      if (dec_en === 1'b1) pulses++;
      n_checks++;
      if (dec_en !== 1'b1 || op_fields !== 6'(i + 8)) begin
        n_fail++; $display("FAIL cen_on%0d got dec_en=%b op=%h", i, dec_en, op_fields);
      end
      cen = 1'b0;
      cyc();
      n_checks++;
      if (dec_en !== 1'b1 || op_fields !== 6'(i + 8)) begin
        n_fail++; $display("FAIL cen_hold%0d got dec_en=%b op=%h", i, dec_en, op_fields);
      end
    end
    cen = 1'b1; ins_valid = 1'b0;
    cyc();
    n_checks++;
    if (pulses != 4 || dec_en !== 1'b0) begin
      n_fail++; $display("FAIL cen_count got pulses=%0d dec_en=%b want 4 0", pulses, dec_en);
    end
  endtask

  task automatic test_reset_mid();
    ins = 16'h9802; ins_valid = 1'b1;
    cyc();
    rst = 1'b1; ins = 16'h3001; con_result = 1'b1;
    cyc();
    n_checks++;
    if ({dec_en, con_en, ram_load, imm_load, rmux_load, illegal} !== 6'd0 || ins_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid got strobes=%b rdy=%b", {dec_en, con_en, ram_load, imm_load, rmux_load, illegal}, ins_ready);
    end
    rst = 1'b0; ins = 16'h3007; con_result = 1'b0;
    cyc();
    ins_valid = 1'b0;
    n_checks++;
    if (dec_en !== 1'b1 || op_fields !== 6'h07 || illegal !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_idle got dec=%b op=%h ill=%b want 1 07 0", dec_en, op_fields, illegal);
    end
    cyc();
  endtask

  task automatic test_random();
    logic [4:0] ops [5] = '{5'h06, 5'h04, 5'h0A, 5'h0C, 5'h13};
    for (int i = 0; i < 600; i++) begin
      int p = $urandom_range(0, 6);
      ins        = {(p < 5) ? ops[p] : 5'($urandom), 11'($urandom)};
      ins_valid  = ($urandom_range(0, 3) != 0);
      cen        = ($urandom_range(0, 4) != 0);
      con_result = 1'($urandom);
      rst        = ($urandom_range(0, 49) == 0);
      cyc();
      n_checks++;
      if ({dec_en, con_en, ram_load, imm_load, rmux_load, st_a0h, st_a1h, illegal, r_field, op_fields, long_imm, ins_ready}
          !== {e_dec, e_con, e_ram, e_imm, e_rmux, e_a0, e_a1, e_ill, e_r, e_op, e_li, 1'b1}) begin
        n_fail++;
        $display("FAIL random%0d got st=%b r=%0d op=%h li=%h rdy=%b want st=%b r=%0d op=%h li=%h", i,
                 {dec_en, con_en, ram_load, imm_load, rmux_load, st_a0h, st_a1h, illegal}, r_field, op_fields, long_imm, ins_ready,
                 {e_dec, e_con, e_ram, e_imm, e_rmux, e_a0, e_a1, e_ill}, e_r, e_op, e_li);
      end
    end
    rst = 1'b0; cen = 1'b1; ins_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_f1();
    test_ldi();
    test_rld();
    test_ifc();
    test_ifc_wait();
    test_illegal();
    test_cen_toggle();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
